sum_block_accumulator: RTL and testbench
========================================

# sum_block_accumulator

Downstream consumer of the 8-bit adder output of the top-level TinyTapeout datapath. It collects a fixed-length block of 8-bit sums over a valid/ready handshake, accumulates them into a wider register with overflow tracking, then holds the block total for a downstream reader. It sits between the combinational adder and the output mux or serialiser of the tile.

## Interface
Parameters:
- ACC_W, 16, accumulator and result width in bits; legal range 8..24.
- BLOCK_LEN, 8, number of samples per block; legal range 2..255.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- clr  input  1  synchronous abort: discard the partial block and the held result.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block can accept a sample this cycle.
- in_data  input  8  unsigned sample (adder sum).
- out_valid  output  1  out_data, out_ovf and out_count hold a finished block.
- out_ready  input  1  downstream takes the result this cycle.
- out_data  output  ACC_W  block total.
- out_ovf  output  1  sticky: the block total exceeded 2^ACC_W-1.
- out_count  output  8  samples accepted so far in the current block; equals BLOCK_LEN while out_valid is high.

## Operation
- Two states. In ACC, in_ready=1 and out_valid=0. In HOLD, in_ready=0 and out_valid=1.
- in_ready and out_valid are decoded only from the registered state. There is no combinational path from in_valid or out_ready.
- Accept occurs when in_valid && in_ready. On accept: acc <= acc + in_data, and count <= count+1.
- If an accept brings count to BLOCK_LEN: move to HOLD. out_data shows the final sum from the next cycle.
- In HOLD, all inputs except rst, clr and out_ready are ignored. on out_ready: acc<=0, count<=0, ovf<=0, and return to ACC.
- Arithmetic is unsigned. in_data is zero-extended to ACC_W+1 bits.
- If bit ACC_W of the sum is set, ovf is set. ovf stays set until the block is released or cleared.
- out_data is the registered acc and is visible in both states. In ACC it shows the partial sum.
- Priority: rst > clr > handshake.
- clr in either state: acc=0, count=0, ovf=0, state=ACC. A sample presented in the same cycle as clr is dropped.
- Reset mid-block or in HOLD: same effect as clr.

## Timing
- Reset values: state=ACC, in_ready=1, out_valid=0, out_data=0, out_ovf=0, out_count=0.
- Input throughput: one sample per cycle while in ACC.
- Latency: out_valid rises on the cycle after the BLOCK_LEN-th accept.
- Minimum block period: BLOCK_LEN+1 cycles. The hold state lasts at least one cycle, and there is no release-and-accept in the same cycle.
- out_ready asserted while out_valid=0 has no effect.
- While out_valid=1 and out_ready=0, all outputs stay stable.

## Configuration
- Macro SUM_ACC_SATURATE_EN.
- Defined: on overflow, acc clamps to 2^ACC_W-1 and stays there for the rest of the block. out_ovf is set.
- Undefined: acc wraps modulo 2^ACC_W. out_ovf is still set.
- The handshake and timing are identical in both builds.

## Test plan
- Reset, then 8 samples of value 10 with in_valid held high (defaults) -> out_valid rises 1 cycle after the 8th accept; out_data=80, out_ovf=0, out_count=8, in_ready=0.
- Hold out_ready=0 for 5 cycles, then pulse it for 1 cycle -> outputs stable for all 5 cycles. The next cycle shows out_valid=0, in_ready=1, out_data=0, out_count=0.
- Gappy in_valid (alternate 1/0) with samples 1..8 -> out_data=36 after the 8th accept. in_data values presented on cycles with in_valid=0 are ignored.
- ACC_W=10, 8 samples of 255 -> with SUM_ACC_SATURATE_EN: out_data=1023 and out_ovf=1. Without it: out_data=2040 mod 1024=1016 and out_ovf=1.
- 3 samples of 50, then clr together with in_valid and in_data=99 -> next cycle out_data=0, out_count=0. Eight further samples of 1 give out_data=8.
- rst asserted in HOLD -> next cycle shows all reset values, and in_ready=1.

Source files
------------

// File: rtl/sum_block_accumulator_if.sv
// Handshake bundle for sum_block_accumulator: sample input side and block-result output side.
interface sum_block_accumulator_if #(
    parameter int unsigned ACC_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic             out_ovf;
    logic [7:0]       out_count;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ovf, out_count
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, out_count
    );
endinterface

// File: rtl/sum_block_accumulator.sv
// Collects BLOCK_LEN 8-bit sums into an ACC_W accumulator with sticky overflow, then holds the total.
// Optional build macro SUM_ACC_SATURATE_EN: clamp the total on overflow instead of wrapping.
module sum_block_accumulator #(
    parameter int unsigned ACC_W     = 16,
    parameter int unsigned BLOCK_LEN = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    sum_block_accumulator_if.slave bus
);
    localparam int unsigned      CNT_W    = 8;
    localparam int unsigned      SUM_W    = ACC_W + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_LEN - 1);
`ifdef SUM_ACC_SATURATE_EN
    localparam logic [ACC_W-1:0] ACC_MAX  = {ACC_W{1'b1}};
`endif

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [SUM_W-1:0] sum_c;

    // One guard bit above the accumulator catches the carry out of every add.
    assign sum_c = SUM_W'(acc_q) + SUM_W'(bus.in_data);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clr) begin
            state_d = ST_ACC;
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (bus.in_valid) begin
                        count_d = count_q + CNT_W'(1);
                        ovf_d   = ovf_q | sum_c[ACC_W];
`ifdef SUM_ACC_SATURATE_EN
                        acc_d   = (ovf_q || sum_c[ACC_W]) ? ACC_MAX : sum_c[ACC_W-1:0];
`else
                        acc_d   = sum_c[ACC_W-1:0];
`endif
                        if (count_q == LAST_IDX) begin
                            state_d = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    // Release only; a sample offered on the release cycle is not taken.
                    if (bus.out_ready) begin
                        state_d = ST_ACC;
                        acc_d   = '0;
                        count_d = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: state_d = ST_ACC;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == ST_ACC);
    assign bus.out_valid = (state_q == ST_HOLD);
    assign bus.out_data  = acc_q;
    assign bus.out_ovf   = ovf_q;
    assign bus.out_count = count_q;
endmodule

// File: tb/tb_sum_block_accumulator.sv
// Bench for sum_block_accumulator: table-driven blocks with a result scoreboard plus corner sequences.
module tb_sum_block_accumulator;
    localparam int unsigned ACC_W     = 16;
    localparam int unsigned ACC_W_S   = 10;
    localparam int unsigned BLOCK_LEN = 8;
    localparam int unsigned MAX_CYC   = 64;

    typedef struct {
        logic [7:0]  base;
        logic [7:0]  step;
        bit          gappy;
        bit          early_ready;
        int unsigned hold_cycles;
        logic [15:0] exp_sum;
    } vec_t;

    typedef struct {
        logic [ACC_W-1:0] data;
        logic             ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic clr;
    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];
    vec_t vecs[7];

    sum_block_accumulator_if #(.ACC_W(ACC_W))   bus ();
    sum_block_accumulator_if #(.ACC_W(ACC_W_S)) bus_s ();

    sum_block_accumulator #(.ACC_W(ACC_W), .BLOCK_LEN(BLOCK_LEN)) dut (
        .clk(clk), .rst(rst), .clr(clr), .bus(bus)
    );
    sum_block_accumulator #(.ACC_W(ACC_W_S), .BLOCK_LEN(BLOCK_LEN)) dut_s (
        .clk(clk), .rst(rst), .clr(clr), .bus(bus_s)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
        check({tag, "_in_ready"},  32'(bus.in_ready), 1);
        check({tag, "_out_data"},  32'(bus.out_data), 0);
        check({tag, "_out_ovf"},   32'(bus.out_ovf), 0);
        check({tag, "_out_count"}, 32'(bus.out_count), 0);
    endtask

    // Drives one block, scoreboards the expected total, optionally stalls, then releases.
    task automatic run_block(input vec_t v);
        int unsigned sent  = 0;
        int unsigned cyc   = 0;
        logic [15:0] model = '0;
        logic [7:0]  smp;
        bit          acc_now;
        bit          done  = 0;
        exp_t        e;
        bus.out_ready = v.early_ready;
        while (!done && cyc < MAX_CYC) begin
            smp          = v.base + 8'(sent) * v.step;
            bus.in_valid = v.gappy ? (cyc % 2 == 0) : 1'b1;
            bus.in_data  = bus.in_valid ? smp : (8'(cyc) ^ 8'hC3);
            acc_now      = bus.in_valid;
            check("acc_in_ready", 32'(bus.in_ready), 1);
            tick();
            cyc++;
            if (acc_now) begin
                sent++;
                model = model + 16'(smp);
            end
            if (sent == BLOCK_LEN) begin
                e.data = model;
                e.ovf  = 1'b0;
                sb.push_back(e);
                done = 1;
            end else begin
                check("partial_out_valid", 32'(bus.out_valid), 0);
                check("partial_count", 32'(bus.out_count), sent);
                check("partial_data", 32'(bus.out_data), 32'(model));
            end
        end
        if (!done) check("block_timeout", 0, 1);
        check("latency_out_valid", 32'(bus.out_valid), 1);
        if (bus.out_valid) begin
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("block_data", 32'(bus.out_data), 32'(e.data));
                check("block_ovf", 32'(bus.out_ovf), 32'(e.ovf));
            end else begin
                check("sb_underflow", 0, 1);
            end
        end
        check("block_table_sum", 32'(bus.out_data), 32'(v.exp_sum));
        check("block_count", 32'(bus.out_count), BLOCK_LEN);
        check("block_in_ready", 32'(bus.in_ready), 0);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h77;
        for (int h = 0; h < int'(v.hold_cycles); h++) begin
            tick();
            check("hold_out_valid", 32'(bus.out_valid), 1);
            check("hold_data", 32'(bus.out_data), 32'(v.exp_sum));
            check("hold_count", 32'(bus.out_count), BLOCK_LEN);
            check("hold_ovf", 32'(bus.out_ovf), 0);
            check("hold_in_ready", 32'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check_idle("release");
    endtask

    task automatic fill_const(input logic [7:0] val);
        bus.in_valid = 1'b1;
        bus.in_data  = val;
        for (int i = 0; i < int'(BLOCK_LEN); i++) tick();
        bus.in_valid = 1'b0;
        check("fill_out_valid", 32'(bus.out_valid), 1);
        check("fill_data", 32'(bus.out_data), 32'(val) * BLOCK_LEN);
    endtask

    initial begin
        int   m;
        logic ovf_m;
        vecs[0] = '{base: 8'd10,  step: 8'd0,  gappy: 0, early_ready: 0, hold_cycles: 5, exp_sum: 16'd80};
        vecs[1] = '{base: 8'd1,   step: 8'd1,  gappy: 1, early_ready: 0, hold_cycles: 0, exp_sum: 16'd36};
        vecs[2] = '{base: 8'd200, step: 8'd5,  gappy: 0, early_ready: 1, hold_cycles: 2, exp_sum: 16'd1740};
        vecs[3] = '{base: 8'd255, step: 8'd0,  gappy: 0, early_ready: 0, hold_cycles: 1, exp_sum: 16'd2040};
        vecs[4] = '{base: 8'd0,   step: 8'd0,  gappy: 1, early_ready: 1, hold_cycles: 0, exp_sum: 16'd0};
        vecs[5] = '{base: 8'd7,   step: 8'd31, gappy: 0, early_ready: 0, hold_cycles: 0, exp_sum: 16'd924};
        vecs[6] = '{base: 8'd1,   step: 8'd0,  gappy: 0, early_ready: 0, hold_cycles: 0, exp_sum: 16'd8};

        rst = 1'b1;
        clr = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.out_ready   = 1'b0;
        bus_s.in_valid  = 1'b0;
        bus_s.in_data   = '0;
        bus_s.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_idle("reset");

        for (int i = 0; i < 6; i++) run_block(vecs[i]);

        // Abort a partial block; the sample offered alongside clr is dropped.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'd50;
        for (int i = 0; i < 3; i++) tick();
        check("clr_pre_data", 32'(bus.out_data), 150);
        check("clr_pre_count", 32'(bus.out_count), 3);
        clr = 1'b1;
        bus.in_data = 8'd99;
        tick();
        clr = 1'b0;
        bus.in_valid = 1'b0;
        check_idle("clr_acc");
        run_block(vecs[6]);

        // clr while holding a finished block.
        fill_const(8'd3);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_idle("clr_hold");

        // rst while holding a finished block.
        fill_const(8'd9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("rst_hold");

        // Narrow accumulator overflow: 8 x 255 into 10 bits.
        m = 0;
        ovf_m = 1'b0;
        bus_s.in_valid = 1'b1;
        bus_s.in_data  = 8'd255;
        for (int i = 1; i <= int'(BLOCK_LEN); i++) begin
            tick();
            m = m + 255;
            if (m > 1023) begin
                ovf_m = 1'b1;
`ifdef SUM_ACC_SATURATE_EN
                m = 1023;
`else
                m = m - 1024;
`endif
            end
            check("ovf_data", 32'(bus_s.out_data), 32'(m));
            check("ovf_flag", 32'(bus_s.out_ovf), 32'(ovf_m));
            check("ovf_count", 32'(bus_s.out_count), 32'(i));
            check("ovf_out_valid", 32'(bus_s.out_valid), (i == int'(BLOCK_LEN)) ? 1 : 0);
        end
`ifdef SUM_ACC_SATURATE_EN
        check("ovf_final", 32'(bus_s.out_data), 1023);
`else
        check("ovf_final", 32'(bus_s.out_data), 1016);
`endif
        tick();
        check("ovf_hold_data", 32'(bus_s.out_data), 32'(m));
        check("ovf_hold_flag", 32'(bus_s.out_ovf), 1);
        check("ovf_hold_count", 32'(bus_s.out_count), BLOCK_LEN);
        bus_s.in_valid  = 1'b0;
        bus_s.out_ready = 1'b1;
        tick();
        bus_s.out_ready = 1'b0;
        check("ovf_rel_data", 32'(bus_s.out_data), 0);
        check("ovf_rel_flag", 32'(bus_s.out_ovf), 0);
        check("ovf_rel_valid", 32'(bus_s.out_valid), 0);
        check("ovf_rel_ready", 32'(bus_s.in_ready), 1);

        check("sb_drained", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
